// File: rtl/sbox_share_stage_pkg.sv
// sbox_share_stage_pkg: shared constants and types for the masked S-box share stage
package sbox_share_stage_pkg;
    localparam int NIBBLE_W = 4;
    localparam int SHARES = 2;
    typedef logic [NIBBLE_W-1:0] share_nibble_t;
endpackage

// File: rtl/sbox_share_stage_fifo_ctrl.sv
// share_fifo_ctrl: pointer/level bookkeeping for the share FIFO; never touches share data
//   clk, rst_n          clock, async active-low reset
//   in_valid, out_ready handshake requests from producer/consumer
//   cap, pop            qualified capture / pop strobes for this cycle
//   wptr, rptr          write / read pointers (wrap modulo DEPTH)
//   level               occupied entries
//   in_ready, out_valid registered status derived from next level
module share_fifo_ctrl #(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic                       out_ready,
    output logic                       cap,
    output logic                       pop,
    output logic [$clog2(DEPTH)-1:0]   wptr,
    output logic [$clog2(DEPTH)-1:0]   rptr,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       in_ready,
    output logic                       out_valid
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    logic [LW-1:0] level_nxt;
    always_comb begin
        cap = in_valid & in_ready;
        pop = out_valid & out_ready;
        level_nxt = level + LW'(cap) - LW'(pop);
    end
    // status flags are registered from the next level so they depend on state only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            level <= '0;
            in_ready <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            wptr <= wptr + PW'(cap);
            rptr <= rptr + PW'(pop);
            level <= level_nxt;
            in_ready <= level_nxt < LW'(DEPTH);
            out_valid <= level_nxt != '0;
        end
    end
endmodule

// File: rtl/sbox_share_stage.sv
// sbox_share_stage: masked two-share nibble FIFO with optional fresh-mask refresh on capture
//   clk, rst_n              clock, async active-low reset
//   in_valid/in_ready       capture handshake for share pair in0/in1
//   r                       fresh mask applied to both shares on capture (REFRESH=1)
//   rnd_req                 pulse the cycle after each capture
//   out_valid/out_ready     pop handshake for head pair out0/out1
//   level                   occupied entries
module sbox_share_stage
    import sbox_share_stage_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter bit REFRESH = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [NIBBLE_W-1:0]    in0,
    input  logic [NIBBLE_W-1:0]    in1,
    output logic                   in_ready,
    input  logic [NIBBLE_W-1:0]    r,
    output logic                   rnd_req,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NIBBLE_W-1:0]    out0,
    output logic [NIBBLE_W-1:0]    out1,
    output logic [$clog2(DEPTH):0] level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    logic cap, pop, load_mem, load_in;
    logic [PW-1:0] wptr, rptr, rptr_nxt;
    share_nibble_t mem0 [DEPTH];
    share_nibble_t mem1 [DEPTH];
    share_nibble_t d0, d1;
    share_fifo_ctrl #(.DEPTH(DEPTH)) ctrl (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .out_ready(out_ready),
        .cap(cap),
        .pop(pop),
        .wptr(wptr),
        .rptr(rptr),
        .level(level),
        .in_ready(in_ready),
        .out_valid(out_valid)
    );
    // each share is masked independently; share 0 and share 1 never meet in logic
    always_comb begin
        d0 = REFRESH ? in0 ^ r : in0;
        d1 = REFRESH ? in1 ^ r : in1;
        rptr_nxt = rptr + PW'(1);
        load_mem = pop && level > LW'(1);
        // new capture becomes head when the stage is, or is about to become, otherwise empty
        load_in = cap && (level == '0 || (pop && level == LW'(1)));
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem0[i] <= '0;
        end else if (cap) begin
            mem0[wptr] <= d0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem1[i] <= '0;
        end else if (cap) begin
            mem1[wptr] <= d1;
        end
    end
    // head registers hold their value when empty to avoid unmasked transitions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out0 <= '0;
        end else if (load_mem) begin
            out0 <= mem0[rptr_nxt];
        end else if (load_in) begin
            out0 <= d0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out1 <= '0;
        end else if (load_mem) begin
            out1 <= mem1[rptr_nxt];
        end else if (load_in) begin
            out1 <= d1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rnd_req <= 1'b0;
        end else begin
            rnd_req <= cap;
        end
    end
endmodule
